adda_adc_capture: RTL and testbench
===================================

// Module: adda_adc_capture
// PURPOSE
//  Triggered ADC sample-capture engine in the ADDA clock domain (clkin = PLL ADDA clock output).
//  Decimates the parallel ADC bus by a programmable divider and detects a level/edge trigger.
//  Captures a programmed number of samples into an internal FWFT FIFO, drained over a valid/ready stream.
// PARAMETERS
//  DATA_W      8   ADC sample width
//  LEN_W       10  width of capture_len
//  FIFO_AW     4   FIFO address width; depth = 2**FIFO_AW (16)
// PORTS
//  clkin        in   1       ADDA clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  arm          in   1       pulse: start a capture sequence
//  abort        in   1       pulse: cancel sequence
//  div          in   16      sample tick every div+1 cycles
//  trig_level   in   DATA_W  trigger threshold (unsigned)
//  trig_edge    in   1       0 = rising, 1 = falling
//  trig_force   in   1       trigger on next tick regardless of data
//  capture_len  in   LEN_W   samples per capture, incl. trigger sample; 0 treated as 1
//  adc_data     in   DATA_W  ADC parallel data
//  m_data       out  DATA_W  FIFO head sample
//  m_valid      out  1       FIFO not empty
//  m_ready      in   1       consumer accepts m_data
//  busy         out  1       state ARMED or CAPTURE
//  done         out  1       state DONE
//  overflow     out  1       sticky: a captured sample was dropped
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, divider count 0, prev sample 0, have_prev 0, all outputs 0.
//  Divider: cnt runs 0..div, tick when cnt==div, then wraps to 0; cleared to 0 on arm accept; div=0 -> tick every cycle.
//  prev register updates with adc_data on every tick; have_prev set on the first tick after arm.
//  FSM IDLE/DONE: arm -> ARMED; FIFO flushed, overflow cleared, cnt cleared. Otherwise holds state.
//  ARMED on tick: trig if trig_force, or have_prev && rising (prev<lvl && adc_data>=lvl) or falling (prev>=lvl && adc_data<lvl).
//   Trig: push adc_data (first captured sample), n=1; if len==1 -> DONE, else -> CAPTURE.
//   Force is level-sampled at the tick only.
//  CAPTURE on tick: push adc_data, n++; when n reaches len -> DONE.
//  Trigger compare and push use adc_data combinationally at the tick edge; sample at edge T is on m_data/m_valid after T (FIFO empty).
//  abort in ARMED/CAPTURE/DONE -> IDLE next edge. FIFO contents and overflow are retained.
//  arm in ARMED/CAPTURE is ignored. abort and arm in the same cycle: abort wins -> IDLE.
//  FIFO: FWFT. Pop when m_valid && m_ready. Push is accepted if not full, or if a pop occurs in the same cycle.
//  FIFO full on push without pop: sample dropped, overflow<=1, sample counter still advances.
//  Pointers are FIFO_AW+1 bits; full/empty by MSB compare. Wrap-around is transparent.
//  Changing div/trig/len while busy is allowed and takes effect at the next tick or compare.
// TESTING
//  1 div=0, lvl=0x80 rising, len=4, adc ramps 0x00+1/cycle, arm, m_ready=1 -> m_data 80,81,82,83, then done=1, busy=0.
//  2 div=3, same ramp, len=3 -> captured values differ by 4 (80,84,88); m_valid pulses once per 4 cycles.
//  3 falling, lvl=0x10, adc constant 0x40 -> busy=1 indefinitely; trig_force=1 -> captures 0x40 x len, done=1.
//  4 m_ready=0, len=20, div=0 -> 16 entries held, overflow=1 after push 17, done after 20 ticks; drain gives first 16 samples in order.
//  5 abort during CAPTURE -> next cycle busy=0, done=0, FIFO still drainable; reset mid-capture -> all outputs 0, m_valid=0.
//  6 arm during CAPTURE -> ignored, count unchanged; arm+abort same cycle -> IDLE; pop+push when full -> no overflow.

Source files
------------

// File: rtl/adda_adc_capture.sv
// Triggered ADC capture engine: decimating tick, level/edge trigger, counted capture
// into a first-word-fall-through FIFO drained over a valid/ready stream.
module adda_adc_capture #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 10,
  parameter int FIFO_AW = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [15:0]       div,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_force,
  input  logic [LEN_W-1:0]  capture_len,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_have_prev;
  logic [LEN_W-1:0]    r_n;
  logic [LEN_W-1:0]    w_n_nxt;
  logic                r_overflow;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [FIFO_AW:0]    r_wr;
  logic [FIFO_AW:0]    r_rd;

  logic                w_tick;
  logic                w_arm_acc;
  logic                w_rise;
  logic                w_fall;
  logic                w_trig;
  logic [LEN_W-1:0]    w_len_eff;
  logic [LEN_W-1:0]    w_n_inc;
  logic                w_push;
  logic                w_push_ok;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;

  assign w_tick    = (r_cnt == div);
  assign w_arm_acc = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Trigger compares the live bus against the previous tick's sample.
  assign w_rise    = (r_prev <  trig_level) && (adc_data >= trig_level);
  assign w_fall    = (r_prev >= trig_level) && (adc_data <  trig_level);
  assign w_trig    = trig_force || (r_have_prev && (trig_edge ? w_fall : w_rise));
  assign w_len_eff = (capture_len == '0) ? LEN_W'(1) : capture_len;
  assign w_n_inc   = r_n + LEN_W'(1);

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_cnt       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else begin
      if (w_arm_acc || w_tick) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 16'd1;
      if (w_tick) r_prev <= adc_data;
      if (w_arm_acc)   r_have_prev <= 1'b0;
      else if (w_tick) r_have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_push      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arm_acc) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && w_trig) begin
          w_push      = 1'b1;
          w_n_nxt     = LEN_W'(1);
          w_state_nxt = (w_len_eff == LEN_W'(1)) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_push  = 1'b1;
          w_n_nxt = w_n_inc;
          // >= so a length shortened mid-capture still terminates
          if (w_n_inc >= w_len_eff) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (abort)          w_state_nxt = S_IDLE;
        else if (w_arm_acc) w_state_nxt = S_ARMED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                     (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
  assign w_pop     = !w_empty && m_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clkin) begin
    if (w_push_ok) r_mem[r_wr[FIFO_AW-1:0]] <= adc_data;
  end

  always_ff @(posedge clkin) begin
    if (reset || w_arm_acc) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + (FIFO_AW+1)'(1);
      if (w_pop)     r_rd <= r_rd + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clkin) begin
    if (reset || w_arm_acc)     r_overflow <= 1'b0;
    else if (w_push && !w_push_ok) r_overflow <= 1'b1;
  end

  assign m_valid  = !w_empty;
  assign m_data   = w_empty ? '0 : r_mem[r_rd[FIFO_AW-1:0]];
  assign busy     = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_adda_adc_capture.sv
// Scoreboard bench for adda_adc_capture: directed captures with expected samples queued
// up front and a negedge monitor comparing every accepted stream beat.
module tb_adda_adc_capture;

  logic        clkin = 1'b0;
  logic        reset;
  logic        arm;
  logic        abort;
  logic [15:0] div;
  logic [7:0]  trig_level;
  logic        trig_edge;
  logic        trig_force;
  logic [9:0]  capture_len;
  logic [7:0]  adc_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  exp_q[$];
  bit          ramp_en  = 1'b0;

  always #5 clkin = ~clkin;

  adda_adc_capture dut (
    .clkin       (clkin),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .div         (div),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .trig_force  (trig_force),
    .capture_len (capture_len),
    .adc_data    (adc_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs move 1ns after the edge; the ADC ramp advances by one per cycle.
  task automatic step();
    @(posedge clkin);
    #1;
    if (ramp_en) adc_data = adc_data + 8'd1;
  endtask

  task automatic wait_valid(input int maxc);
    int i = 0;
    while (!m_valid && i < maxc) begin
      step();
      i++;
    end
    check("wait_valid", m_valid, 1);
  endtask

  task automatic wait_done(input int maxc);
    int i = 0;
    while (!done && i < maxc) begin
      step();
      i++;
    end
    check("wait_done", done, 1);
  endtask

  task automatic wait_drain(input int maxc);
    int i = 0;
    while (exp_q.size() != 0 && i < maxc) begin
      step();
      i++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic push_ramp(input logic [7:0] first, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(first + 8'(i));
  endtask

  // Arm with the ramp so the arm edge sees 0x70; the next edge sees 0x71, and so on.
  task automatic arm_ramp();
    adc_data = 8'h70;
    ramp_en  = 1'b1;
    arm      = 1'b1;
    step();
    arm      = 1'b0;
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clkin);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; arm = 1'b0; abort = 1'b0; div = 16'd0;
    trig_level = 8'h80; trig_edge = 1'b0; trig_force = 1'b0;
    capture_len = 10'd4; adc_data = 8'h00; m_ready = 1'b0;
    step();
    step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    step();

    // 1: div=0 rising at 0x80, len 4
    m_ready = 1'b1;
    push_ramp(8'h80, 4);
    arm_ramp();
    check("t1_busy", busy, 1);
    wait_done(64);
    check("t1_busy_end", busy, 0);
    wait_drain(10);

    // 2: div=3, ticks every 4 cycles -> 80,84,88
    div = 16'd3;
    capture_len = 10'd3;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h88);
    arm_ramp();
    wait_done(100);
    wait_drain(10);

    // 3: falling trigger never satisfied on a flat bus, then forced
    div = 16'd0;
    ramp_en = 1'b0;
    adc_data = 8'h40;
    trig_edge = 1'b1;
    trig_level = 8'h10;
    capture_len = 10'd3;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (20) step();
    check("t3_busy_wait", busy, 1);
    check("t3_done_wait", done, 0);
    check("t3_valid_wait", m_valid, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h40);
    trig_force = 1'b1;
    step();
    trig_force = 1'b0;
    wait_done(10);
    wait_drain(10);

    // 4: stalled consumer, 20 samples into 16 entries
    trig_edge = 1'b0;
    trig_level = 8'h80;
    capture_len = 10'd20;
    m_ready = 1'b0;
    arm_ramp();
    wait_valid(64);
    repeat (15) step();
    check("t4_ovf_at16", overflow, 0);
    step();
    check("t4_ovf_at17", overflow, 1);
    wait_done(16);
    push_ramp(8'h80, 16);
    m_ready = 1'b1;
    wait_drain(40);
    check("t4_empty", m_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // 5a: abort during capture on a non-tick edge
    div = 16'd3;
    capture_len = 10'd10;
    m_ready = 1'b0;
    arm_ramp();
    check("t5_ovf_cleared", overflow, 0);
    wait_valid(100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_valid", m_valid, 1);
    exp_q.push_back(8'h80);
    m_ready = 1'b1;
    wait_drain(10);
    m_ready = 1'b0;

    // 5b: reset mid-capture
    div = 16'd0;
    arm_ramp();
    wait_valid(64);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);

    // 6a: arm during capture is ignored
    capture_len = 10'd6;
    m_ready = 1'b1;
    push_ramp(8'h80, 6);
    arm_ramp();
    wait_valid(64);
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("t6_busy", busy, 1);
    wait_done(10);
    wait_drain(10);

    // 6b: arm and abort together from DONE
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    check("t6_arm_abort_busy", busy, 0);
    check("t6_arm_abort_done", done, 0);

    // 6c: push while full with a simultaneous pop is not an overflow
    capture_len = 10'd17;
    m_ready = 1'b0;
    push_ramp(8'h80, 17);
    arm_ramp();
    wait_valid(64);
    repeat (15) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t6_full_pp_ovf", overflow, 0);
    check("t6_full_pp_done", done, 1);
    m_ready = 1'b1;
    wait_drain(40);
    check("t6_ovf_end", overflow, 0);

    repeat (4) step();
    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
